// File: rtl/kanagawa_hal_shared_pipe_arbiter.sv
// Round-robin arbiter feeding a shared external register chain, with a shadow
// pipeline that routes each result back to its requester and a drain/clear flush.
module kanagawa_hal_shared_pipe_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [WIDTH-1:0]                pipe_in,
  output logic                            pipe_clr,
  input  logic [WIDTH-1:0]                pipe_out,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [WIDTH-1:0]                rsp_data,
  input  logic                            flush,
  output logic                            flush_done,
  output logic                            busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR, DONE} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [IDW-1:0]               r_ptr;
  logic [LATENCY-1:0]           r_sh_vld;
  logic [LATENCY-1:0][IDW-1:0]  r_sh_id;
  logic                         w_arb_en;
  logic                         w_gnt_vld;
  logic [IDW-1:0]               w_gnt_id;

  // rst_n gates the grant so req_ready/pipe_in are quiet while reset is held.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] w_idx;
    w_arb_en  = rst_n && (r_state == RUN) && !flush;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      w_idx = idx[IDW-1:0];
      if (w_arb_en && !w_gnt_vld && req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = w_gnt_vld && (w_gnt_id == k[IDW-1:0]);
      rsp_valid[k] = r_sh_vld[LATENCY-1] && (r_sh_id[LATENCY-1] == k[IDW-1:0]);
    end
    pipe_in    = w_gnt_vld ? req_data[w_gnt_id] : '0;
    rsp_data   = pipe_out;
    pipe_clr   = (r_state == CLEAR);
    flush_done = (r_state == DONE);
    busy       = (r_state != RUN);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (flush) w_state_nxt = DRAIN;
      DRAIN:   if (r_sh_vld == '0) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = DONE;
      DONE:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (32'(w_gnt_id) == NUM_REQ - 1) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Shadow tags advance in lockstep with the external chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_vld <= '0;
      r_sh_id  <= '0;
    end else begin
      r_sh_vld[0] <= w_gnt_vld;
      r_sh_id[0]  <= w_gnt_id;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        r_sh_vld[k] <= r_sh_vld[k-1];
        r_sh_id[k]  <= r_sh_id[k-1];
      end
      if (r_state == CLEAR) r_sh_vld <= '0;
    end
  end

endmodule

// File: tb/tb_kanagawa_hal_shared_pipe_arbiter.sv
// Directed bench for the shared-pipe arbiter with a 3-stage clearable chain model.
module tb_kanagawa_hal_shared_pipe_arbiter;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req_valid = '0;
  logic [3:0][7:0] req_data = '0;
  logic [3:0]      req_ready;
  logic [7:0]      pipe_in;
  logic            pipe_clr;
  logic [7:0]      pipe_out;
  logic [3:0]      rsp_valid;
  logic [7:0]      rsp_data;
  logic            flush = 1'b0;
  logic            flush_done;
  logic            busy;

  logic [7:0] ch0 = '0, ch1 = '0, ch2 = '0;
  assign pipe_out = ch2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pipe_clr) begin
      ch0 <= '0; ch1 <= '0; ch2 <= '0;
    end else begin
      ch0 <= pipe_in; ch1 <= ch0; ch2 <= ch1;
    end
  end

  kanagawa_hal_shared_pipe_arbiter #(
    .WIDTH(8), .NUM_REQ(4), .LATENCY(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_in(pipe_in), .pipe_clr(pipe_clr), .pipe_out(pipe_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  // Flush scenario, cycles 0..12: req_ready, rsp_valid, pipe_clr, flush_done, busy.
  localparam logic [3:0] T4_RDY [13] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0,
                                         4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h1};
  localparam logic [3:0] T4_RSP [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2,
                                         4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [12:0] T4_CLR  = 13'b0_0010_0000_0000;
  localparam logic [12:0] T4_DONE = 13'b0_0100_0000_0000;
  localparam logic [12:0] T4_BUSY = 13'b0_0111_1100_0000;
  localparam logic [12:0] T4_FLSH = 13'b0_0100_1010_0000;
  localparam int          T2_GNT [6] = '{0, 1, 2, 3, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] v, input logic fl);
    @(posedge clk);
    #1;
    rst_n     = rst;
    req_valid = v;
    flush     = fl;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    flush     = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_pipe_in", 32'(pipe_in), 32'h0);
    check("rst_rsp", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_clr_done", 32'({pipe_clr, flush_done}), 32'h0);
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  initial begin
    logic [3:0] exp_rsp;

    // Single request, response after LATENCY cycles.
    req_data    = '0;
    req_data[2] = 8'hA5;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, (c == 0) ? 4'b0100 : 4'b0000, 1'b0);
      if (c == 0) begin
        check("t1_ready", 32'(req_ready), 32'h4);
        check("t1_pipe_in", 32'(pipe_in), 32'hA5);
      end
      check("t1_rsp", 32'(rsp_valid), (c == 3) ? 32'h4 : 32'h0);
      if (c == 3) check("t1_rsp_data", 32'(rsp_data), 32'hA5);
    end

    // Continuous four-way contention rotates 0,1,2,3,0,1.
    for (int i = 0; i < 4; i++) req_data[i] = 8'(8'h10 + i);
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(1'b1, (c < 6) ? 4'hF : 4'h0, 1'b0);
      if (c < 6) begin
        check("t2_ready", 32'(req_ready), 32'(1) << T2_GNT[c]);
        check("t2_pipe_in", 32'(pipe_in), 32'h10 + 32'(T2_GNT[c]));
      end
      exp_rsp = (c >= 3) ? 4'(1 << T2_GNT[c-3]) : 4'h0;
      check("t2_rsp", 32'(rsp_valid), 32'(exp_rsp));
      if (c >= 3) check("t2_rsp_data", 32'(rsp_data), 32'h10 + 32'(T2_GNT[c-3]));
    end

    // Pointer advance past the last index wraps to 0.
    do_reset();
    step(1'b1, 4'b1000, 1'b0); check("t3_c0", 32'(req_ready), 32'h8);
    step(1'b1, 4'b0000, 1'b0); check("t3_c1", 32'(req_ready), 32'h0);
    step(1'b1, 4'b1010, 1'b0); check("t3_c2", 32'(req_ready), 32'h2);
    step(1'b1, 4'b1010, 1'b0); check("t3_c3", 32'(req_ready), 32'h8);

    // Flush with three responses in flight; repeated flush in DRAIN and DONE ignored.
    for (int i = 0; i < 4; i++) req_data[i] = 8'(8'h20 + i);
    do_reset();
    for (int c = 0; c < 13; c++) begin
      step(1'b1, (c < 2) ? 4'h0 : 4'hF, T4_FLSH[c]);
      check("t4_ready", 32'(req_ready), 32'(T4_RDY[c]));
      check("t4_rsp", 32'(rsp_valid), 32'(T4_RSP[c]));
      check("t4_clr", 32'(pipe_clr), 32'(T4_CLR[c]));
      check("t4_done", 32'(flush_done), 32'(T4_DONE[c]));
      check("t4_busy", 32'(busy), 32'(T4_BUSY[c]));
      if (c == 5) check("t4_pipe_in_idle", 32'(pipe_in), 32'h0);
      if (T4_RSP[c] != 4'h0)
        check("t4_rsp_data", 32'(rsp_data), 32'h20 + 32'($clog2(T4_RSP[c])));
    end

    // Reset with two payloads in flight drops them; restart from index 0 pointer.
    req_data[1] = 8'h31;
    req_data[2] = 8'h32;
    do_reset();
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0110, 1'b0); check("t5_g1", 32'(req_ready), 32'h2);
    step(1'b1, 4'b0110, 1'b0); check("t5_g2", 32'(req_ready), 32'h4);
    step(1'b0, 4'b0110, 1'b0);
    check("t5_rst_rsp", 32'(rsp_valid), 32'h0);
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    check("t5_rst_pipe_in", 32'(pipe_in), 32'h0);
    step(1'b0, 4'b0110, 1'b0); check("t5_rsp_c5", 32'(rsp_valid), 32'h0);
    step(1'b1, 4'b0110, 1'b0);
    check("t5_regrant", 32'(req_ready), 32'h2);
    check("t5_rsp_c6", 32'(rsp_valid), 32'h0);
    step(1'b1, 4'b0000, 1'b0); check("t5_rsp_c7", 32'(rsp_valid), 32'h0);
    step(1'b1, 4'b0000, 1'b0); check("t5_rsp_c8", 32'(rsp_valid), 32'h0);
    step(1'b1, 4'b0000, 1'b0);
    check("t5_rsp_c9", 32'(rsp_valid), 32'h2);
    check("t5_rsp_data", 32'(rsp_data), 32'h31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
